// File: rtl/aes_decrypt_top.sv
// aes_decrypt_top: iterative AES-128 inverse cipher, one round per clock.
// A start in IDLE captures cipher_text/cipher_key. The key is expanded forward to
// round key 10, and then the inverse rounds run with a reverse key schedule.
// Ports:
//   clk, rstn (async, active-low), start (sampled in IDLE only)
//   cipher_text, cipher_key [127:0]: byte 0 sits in [127:120]
//   done: one-cycle pulse when plain_text is valid
//   completed_round [9:0]: thermometer progress of the inverse rounds
//   plain_text [127:0]: held until the FINAL edge of the next operation
// Only N=4 (Nk=4, Nr=10) is supported.
//
// state | meaning
// IDLE  | waiting for start
// KEXP  | forward expansion, key reg advances rk0 -> rk10 (10 cycles)
// INIT  | state ^= rk10, key reg -> rk9
// ROUND | inverse rounds 9..1 with key reg stepping backwards
// FINAL | last inverse round without InvMixColumns, load plain_text
// DONE  | done pulse
module aes_decrypt_top #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [127:0] cipher_text,
  input  logic [127:0] cipher_key,
  output logic         done,
  output logic [9:0]   completed_round,
  output logic [127:0] plain_text
);
  localparam int NR = N + 6;

  typedef enum logic [2:0] {S_IDLE, S_KEXP, S_INIT, S_ROUND, S_FINAL, S_DONE} state_t;
  state_t state_q, state_d;

  logic [127:0] st_q, key_q;
  logic [7:0]   rcon_q;
  logic [3:0]   cnt_q;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Exact inverse of xtime, used to walk Rcon backwards.
  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    return b[0] ? ({1'b1, b[7:1]} ^ 8'h0d) : {1'b0, b[7:1]};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse computed as x^254. This maps 0 to 0, as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] t;
    t = gmul(gmul(x, x), x);        // x^3
    t = gmul(gmul(t, t), x);        // x^7
    t = gmul(gmul(t, t), x);        // x^15
    t = gmul(gmul(t, t), x);        // x^31
    t = gmul(gmul(t, t), x);        // x^63
    t = gmul(gmul(t, t), x);        // x^127
    return gmul(t, t);              // x^254
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte (row r, column c) is located at index 4c+r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  // One SubWord path serves both directions. Going forward it takes w3 of the
  // current key. Going backwards it takes the recovered w3, which is w7 ^ w6.
  logic [31:0]  sw_in, f_word;
  logic [7:0]   rc;
  logic [31:0]  n0, n1, n2, n3, p0, p1, p2, p3;
  logic [127:0] key_fwd, key_rev, isb, round_out;

  assign sw_in  = (state_q == S_KEXP) ? key_q[31:0] : (key_q[31:0] ^ key_q[63:32]);
  assign rc     = (state_q == S_INIT) ? 8'h36 : rcon_q;
  assign f_word = sub_word({sw_in[23:0], sw_in[31:24]}) ^ {rc, 24'h000000};

  assign n0 = key_q[127:96] ^ f_word;
  assign n1 = key_q[95:64] ^ n0;
  assign n2 = key_q[63:32] ^ n1;
  assign n3 = key_q[31:0] ^ n2;
  assign key_fwd = {n0, n1, n2, n3};

  assign p3 = key_q[31:0] ^ key_q[63:32];
  assign p2 = key_q[63:32] ^ key_q[95:64];
  assign p1 = key_q[95:64] ^ key_q[127:96];
  assign p0 = key_q[127:96] ^ f_word;
  assign key_rev = {p0, p1, p2, p3};

  assign isb       = inv_sub_bytes(inv_shift_rows(st_q));
  assign round_out = inv_mix(isb ^ key_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_KEXP;
      S_KEXP:  if (cnt_q == 4'd0) state_d = S_INIT;
      S_INIT:  state_d = S_ROUND;
      S_ROUND: if (cnt_q == 4'd0) state_d = S_FINAL;
      S_FINAL: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done = 1'b0;
    if (state_q == S_DONE) done = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q            <= '0;
      key_q           <= '0;
      rcon_q          <= '0;
      cnt_q           <= '0;
      completed_round <= '0;
      plain_text      <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          st_q            <= cipher_text;
          key_q           <= cipher_key;
          rcon_q          <= 8'h01;
          cnt_q           <= 4'(NR - 1);
          completed_round <= '0;
        end
        S_KEXP: begin
          key_q  <= key_fwd;
          rcon_q <= xtime(rcon_q);
          cnt_q  <= cnt_q - 4'd1;
        end
        S_INIT: begin
          st_q   <= st_q ^ key_q;
          key_q  <= key_rev;
          rcon_q <= 8'h1b;
          cnt_q  <= 4'(NR - 2);
        end
        S_ROUND: begin
          st_q            <= round_out;
          key_q           <= key_rev;
          rcon_q          <= inv_xtime(rcon_q);
          cnt_q           <= cnt_q - 4'd1;
          completed_round <= {completed_round[8:0], 1'b1};
        end
        S_FINAL: begin
          plain_text      <= isb ^ key_q;
          completed_round <= {completed_round[8:0], 1'b1};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_decrypt_top.sv
// tb_aes_decrypt_top: scoreboard bench for aes_decrypt_top using published AES-128 vectors.
module tb_aes_decrypt_top;
  logic         clk = 1'b0;
  logic         rstn, start;
  logic [127:0] cipher_text, cipher_key;
  logic         done;
  logic [9:0]   completed_round;
  logic [127:0] plain_text;

  aes_decrypt_top #(.N(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .cipher_text(cipher_text),
    .cipher_key(cipher_key), .done(done), .completed_round(completed_round),
    .plain_text(plain_text)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] pt;
    int           e0;
  } exp_t;
  exp_t sbq[$];

  int total = 0;
  int bad = 0;
  logic         in_reset;
  logic [127:0] held_pt;
  logic [9:0]   held_cr;
  logic [127:0] vk[5], vc[5], vp[5];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compares the in-flight operation (queue head) against a model of
  // progress, the plain_text hold, and done timing.
  always @(negedge clk) begin
    int d;
    logic [9:0]   ecr;
    logic [127:0] ept;
    if (!in_reset) begin
      if (sbq.size() > 0) begin
        d = cyc - sbq[0].e0;
        if (d <= 11)      ecr = 10'h000;
        else if (d >= 21) ecr = 10'h3ff;
        else              ecr = 10'((1 << (d - 11)) - 1);
        ept = (d >= 21) ? sbq[0].pt : held_pt;
        chk("completed_round", 128'(completed_round), 128'(ecr));
        chk("plain_text", plain_text, ept);
        if (done) begin
          chk("done_latency", 128'(d), 128'(21));
          held_pt = sbq[0].pt;
          held_cr = 10'h3ff;
          void'(sbq.pop_front());
        end else if (d > 30) begin
          chk("done_timeout", 128'(done), 128'(1));
          void'(sbq.pop_front());
        end
      end else begin
        chk("idle_done", 128'(done), 128'(0));
        chk("idle_completed_round", 128'(completed_round), 128'(held_cr));
        chk("idle_plain_text", plain_text, held_pt);
      end
    end
  end

  // Called at negedge+1; start gets sampled at the next rising edge (E0).
  task automatic run_op(input int v, output int e0);
    exp_t e;
    cipher_text = vc[v];
    cipher_key  = vk[v];
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    e.pt = vp[v];
    e.e0 = e0;
    sbq.push_back(e);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      chk("wait_idle_timeout", 128'(sbq.size()), 128'(0));
      sbq.delete();
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    int e0, e1;
    exp_t e;
    vk[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c; vc[0] = 128'h3925841d02dc09fbdc118597196a0b32;
    vp[0] = 128'h3243f6a8885a308d313198a2e0370734;
    vk[1] = 128'h000102030405060708090a0b0c0d0e0f; vc[1] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    vp[1] = 128'h00112233445566778899aabbccddeeff;
    vk[2] = 128'h2b7e151628aed2a6abf7158809cf4f3c; vc[2] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    vp[2] = 128'h6bc1bee22e409f96e93d7e117393172a;
    vk[3] = 128'h2b7e151628aed2a6abf7158809cf4f3c; vc[3] = 128'hf5d3d58503b9699de785895a96fdbaaf;
    vp[3] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    vk[4] = 128'h0;                                vc[4] = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    vp[4] = 128'h0;

    in_reset = 1'b1;
    held_pt = '0;
    held_cr = '0;
    rstn = 1'b0;
    start = 1'b0;
    cipher_text = '0;
    cipher_key = '0;
    #2;
    chk("reset_done", 128'(done), 128'(0));
    chk("reset_completed_round", 128'(completed_round), 128'(0));
    chk("reset_plain_text", plain_text, 128'(0));
    @(negedge clk);
    @(negedge clk);
    #1;
    rstn = 1'b1;
    in_reset = 1'b0;

    // Plain decrypts of the directed vectors.
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      #1;
      run_op(v, e0);
      wait_idle();
    end

    // Start held high with the inputs changing after capture. The second
    // acceptance happens only in the first IDLE cycle (E23), using the inputs at that time.
    cipher_text = vc[2];
    cipher_key  = vk[2];
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    e.pt = vp[2];
    e.e0 = e0;
    sbq.push_back(e);
    for (int k = 1; k < 30; k++) begin
      @(negedge clk);
      #1;
      if (k < 18 && k % 2 == 1) begin
        cipher_text = vc[4];
        cipher_key  = vk[4];
      end else begin
        cipher_text = vc[3];
        cipher_key  = vk[3];
      end
      if (cyc == e0 + 22) begin
        e.pt = vp[3];
        e.e0 = e0 + 23;
        sbq.push_back(e);
      end
    end
    start = 1'b0;
    wait_idle();

    // Reset asserted in the middle of ROUND.
    run_op(1, e0);
    for (int i = 0; i < 40 && cyc < e0 + 15; i++) @(negedge clk);
    #1;
    in_reset = 1'b1;
    rstn = 1'b0;
    #1;
    chk("abort_done", 128'(done), 128'(0));
    chk("abort_completed_round", 128'(completed_round), 128'(0));
    chk("abort_plain_text", plain_text, 128'(0));
    sbq.delete();
    held_pt = '0;
    held_cr = '0;
    @(negedge clk);
    #1;
    rstn = 1'b1;
    in_reset = 1'b0;
    @(negedge clk);
    #1;
    run_op(0, e0);
    wait_idle();

    // Back-to-back: the second start is presented in the first IDLE cycle after DONE.
    run_op(1, e0);
    for (int i = 0; i < 40 && cyc < e0 + 22; i++) @(negedge clk);
    #1;
    run_op(4, e1);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
